frame_tx_scheduler: RTL and testbench

- Sits between the sobel output and uart_transmitter.
- Buffers filtered pixel bytes in a small FIFO and applies backpressure to the producer.
- Sequences one byte at a time into the UART using its data_valid / tx_done handshake.
- Optionally prefixes a 4-byte dimension header. Counts H*W pixels per frame and signals frame completion.

---
 rtl/frame_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_frame_tx_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: buffers pixel bytes and feeds them one at a time to a UART; define HEADER_EN to prefix a W/H header
module frame_tx_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] H,
  input  logic [15:0] W,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = FIFO_DEPTH[ADDR_W:0];
`ifdef HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR, ISSUE, WAIT_TX, DONE} state_t;
  logic [15:0] h_r, w_r;
  logic [2:0]  hdr_idx;
  logic [7:0]  hdr_byte;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, DONE} state_t;
`endif
  state_t state, nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [ADDR_W:0] cnt;
  logic [31:0] total, rx_cnt, tx_cnt;
  logic full, empty, push, pop, launch;
  assign full = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  assign pix_ready = busy && !full && (rx_cnt < total);
  assign push = pix_valid && pix_ready;
  assign pop = state == ISSUE && tx_cnt != total && !empty;
  assign launch = state == IDLE && start;
`ifdef HEADER_EN
  assign hdr_byte = hdr_idx[1] ? (hdr_idx[0] ? h_r[7:0] : h_r[15:8])
                               : (hdr_idx[0] ? w_r[7:0] : w_r[15:8]);
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
`ifdef HEADER_EN
      IDLE:    nxt = start ? HDR : IDLE;
      HDR:     nxt = WAIT_TX;
      WAIT_TX: nxt = !tx_done ? WAIT_TX : !hdr_idx[2] ? HDR : tx_cnt == total ? DONE : ISSUE;
`else
      IDLE:    nxt = start ? ISSUE : IDLE;
      WAIT_TX: nxt = !tx_done ? WAIT_TX : tx_cnt == total ? DONE : ISSUE;
`endif
      ISSUE:   nxt = tx_cnt == total ? DONE : !empty ? WAIT_TX : ISSUE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= pix_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      total <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      overflow <= 1'b0;
`ifdef HEADER_EN
      h_r <= '0;
      w_r <= '0;
      hdr_idx <= '0;
`endif
    end else begin
      tx_valid <= 1'b0;
      if (launch) begin
        // a new frame flushes whatever the previous one left in the buffer
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        total <= 32'(H) * 32'(W);
        rx_cnt <= '0;
        tx_cnt <= '0;
`ifdef HEADER_EN
        h_r <= H;
        w_r <= W;
        hdr_idx <= '0;
`endif
      end else begin
        if (push) begin
          wp <= wp + 1'b1;
          rx_cnt <= rx_cnt + 1;
        end
        if (pop) begin
          tx_data <= mem[rp];
          tx_valid <= 1'b1;
          rp <= rp + 1'b1;
          tx_cnt <= tx_cnt + 1;
        end
        cnt <= cnt + CW'(push) - CW'(pop);
        if (pix_valid && busy && full && rx_cnt < total) overflow <= 1'b1;
`ifdef HEADER_EN
        if (state == HDR) begin
          tx_data <= hdr_byte;
          tx_valid <= 1'b1;
          hdr_idx <= hdr_idx + 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: random frames through a depth-4 scheduler, scoreboard on the UART byte stream
module tb_frame_tx_scheduler;
  localparam int DEPTH = 4;
`ifdef HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif
  logic clk = 0, reset = 1, start = 0, pix_valid = 0, tx_done = 0;
  logic [15:0] h = 0, w = 0;
  logic [7:0] pix_data = 0;
  logic pix_ready, tx_valid, busy, frame_done, overflow;
  logic [7:0] tx_data;
  frame_tx_scheduler #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .H(h), .W(w),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int vectors = 0, fails = 0;
  logic [7:0] exp_q[$];
  int acc = 0, pops = 0, total_m = 0, hdr_left = 0, lat_min = 1, lat_max = 1;
  bit busy_m = 0, ovf_m = 0, outstanding = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask
  // monitor: every tx_valid pulse pops the scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) outstanding = 0;
    else if (tx_valid) begin
      check("tx_valid before tx_done", 32'(outstanding), 0);
      outstanding = 1;
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected tx byte: got %0h, want none", tx_data);
      end else check("tx byte", 32'(tx_data), 32'(exp_q.pop_front()));
      if (hdr_left > 0) hdr_left--;
      else pops++;
    end
  end
  // UART model: one tx_done pulse some cycles after each accepted byte
  initial forever begin
    @(negedge clk);
    if (tx_valid && !reset) begin
      repeat ($urandom_range(lat_max, lat_min)) @(negedge clk);
      tx_done = 1;
      outstanding = 0;
      @(negedge clk);
      tx_done = 0;
    end
  end
  // mode 0 honours pix_ready, 1 ignores it, 2 honours it but keeps offering past the frame end
  task automatic step(input int mode, input int prob);
    bit rdy, v;
    @(negedge clk);
    #1;
    start = 0;
    check("overflow", 32'(overflow), 32'(ovf_m));
    rdy = busy_m && (acc - pops) < DEPTH && acc < total_m;
    check("pix_ready", 32'(pix_ready), 32'(rdy));
    v = ($urandom_range(99) < prob) && (mode == 1 || rdy || (mode == 2 && acc >= total_m));
    pix_valid = v;
    pix_data = rdy ? 8'($urandom) : 8'hEE;
    if (v && rdy) begin
      exp_q.push_back(pix_data);
      acc++;
    end
    if (v && busy_m && !rdy && acc < total_m) ovf_m = 1;
  endtask
  task automatic do_reset();
    reset = 1;
    start = 0;
    pix_valid = 0;
    @(negedge clk);
    #1;
    check("rst pix_ready", 32'(pix_ready), 0);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst busy", 32'(busy), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst overflow", 32'(overflow), 0);
    reset = 0;
    exp_q.delete();
    acc = 0;
    pops = 0;
    total_m = 0;
    hdr_left = 0;
    busy_m = 0;
    ovf_m = 0;
  endtask
  task automatic run_frame(input logic [15:0] fh, input logic [15:0] fw, input int mode, input int prob,
                           input int lmin, input int lmax, input int reset_after, input bit late_start);
    int n;
    bit done;
    lat_min = lmin;
    lat_max = lmax;
    step(0, 0);
    h = fh;
    w = fw;
    start = 1;
    total_m = fh * fw;
    acc = 0;
    pops = 0;
    hdr_left = HDR_N;
    busy_m = 1;
`ifdef HEADER_EN
    exp_q.push_back(fw[15:8]);
    exp_q.push_back(fw[7:0]);
    exp_q.push_back(fh[15:8]);
    exp_q.push_back(fh[7:0]);
`endif
    step(0, 0);
    check("busy after start", 32'(busy), 1);
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      step(mode, prob);
      n++;
      if (reset_after > 0 && pops >= reset_after) begin
        do_reset();
        return;
      end
      if (late_start && outstanding) begin
        start = 1;
        h = 9;
        w = 9;
        late_start = 0;
      end
      done = frame_done;
    end
    if (!done) begin
      vectors++;
      fails++;
      $display("FAIL frame_done timeout: got none after %0d cycles, want a pulse", n);
      do_reset();
      return;
    end
    if (total_m == 0) check("zero frame latency ok", 32'(n <= 3 + HDR_N * (lmax + 3)), 1);
    check("pixel bytes sent", pops, total_m);
    check("scoreboard drained", exp_q.size(), 0);
    busy_m = 0;
    step(0, 0);
    check("busy after frame", 32'(busy), 0);
    check("frame_done width", 32'(frame_done), 0);
  endtask
  initial begin
    do_reset();
    run_frame(2, 3, 0, 100, 20, 20, 0, 0);
    run_frame(1, 8, 0, 100, 20, 20, 0, 0);
    run_frame(1, 8, 1, 100, 20, 20, 0, 0);
    check("overflow sticky", 32'(overflow), 1);
    run_frame(0, 5, 0, 100, 5, 5, 0, 0);
    run_frame(2, 3, 0, 100, 10, 10, 3, 0);
    repeat (40) step(1, 50);
    check("idle after stray tx_done", 32'(busy), 0);
    run_frame(2, 3, 2, 100, 5, 5, 0, 1);
    for (int i = 0; i < 12; i++)
      run_frame(16'($urandom_range(4)), 16'($urandom_range(5)), int'($urandom_range(2)),
                int'($urandom_range(100, 30)), 1, int'($urandom_range(15, 1)), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
